// File: rtl/debug_dump_tx.sv
// Serialises a debug snapshot (header, PC, register file, data memory) into a byte stream
// for a UART-style sink. Optional trailing XOR checksum byte is enabled by DUMP_CHECKSUM_EN.
module debug_dump_tx #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32,
    parameter int MEM_WORDS  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_pc,
    output logic [4:0]            o_reg_addr,
    input  logic [DATA_WIDTH-1:0] i_reg_data,
    output logic [DATA_WIDTH-1:0] o_mem_addr,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [3:0]            dbg_state
);

    // Byte handshake: a byte moves on a rising edge where o_tx_valid and i_tx_ready are both 1;
    // while o_tx_valid=1 and i_tx_ready=0, o_tx_data and o_tx_valid do not change.

    localparam int RIW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
    localparam int MIW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [RIW-1:0] REG_LAST = RIW'(REG_COUNT - 1);
    localparam logic [MIW-1:0] MEM_LAST = MIW'(MEM_WORDS - 1);

    typedef enum logic [3:0] {
        IDLE,
        HEADER,
        PC,
        REG_FETCH,
        REG_SEND,
        MEM_FETCH,
        MEM_SEND,
        CSUM,
        DONE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [31:0]     shift_q;
    logic [1:0]      byte_cnt_q;
    logic            fetch_wait_q;
    logic [RIW-1:0]  reg_idx_q;
    logic [MIW-1:0]  mem_idx_q;
    logic [RIW-1:0]  reg_idx_next;
    logic [MIW-1:0]  mem_idx_next;
    logic            byte_last;
    logic            reg_last;
    logic            mem_last;
    logic            tx_fire;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]      csum_q;
`endif

    assign byte_last    = (byte_cnt_q == 2'd3);
    assign reg_last     = (reg_idx_q == REG_LAST);
    assign mem_last     = (mem_idx_q == MEM_LAST);
    assign reg_idx_next = reg_idx_q + RIW'(1);
    assign mem_idx_next = mem_idx_q + MIW'(1);
    assign tx_fire      = o_tx_valid & i_tx_ready;
    assign dbg_state    = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        o_tx_valid = 1'b0;
        o_tx_data  = 8'h00;
        o_done     = 1'b0;
        o_busy     = 1'b1;
        case (state_q)
            IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    state_d = HEADER;
                end
            end
            HEADER: begin
                o_tx_valid = 1'b1;
                o_tx_data  = 8'hA5;
                if (i_tx_ready) begin
                    state_d = PC;
                end
            end
            PC: begin
                o_tx_valid = 1'b1;
                o_tx_data  = shift_q[31:24];
                if (i_tx_ready && byte_last) begin
                    state_d = REG_FETCH;
                end
            end
            REG_FETCH: begin
                // Second fetch cycle is when the read data has arrived.
                if (fetch_wait_q) begin
                    state_d = REG_SEND;
                end
            end
            REG_SEND: begin
                o_tx_valid = 1'b1;
                o_tx_data  = shift_q[31:24];
                if (i_tx_ready && byte_last) begin
                    state_d = reg_last ? MEM_FETCH : REG_FETCH;
                end
            end
            MEM_FETCH: begin
                if (fetch_wait_q) begin
                    state_d = MEM_SEND;
                end
            end
            MEM_SEND: begin
                o_tx_valid = 1'b1;
                o_tx_data  = shift_q[31:24];
                if (i_tx_ready && byte_last) begin
`ifdef DUMP_CHECKSUM_EN
                    state_d = mem_last ? CSUM : MEM_FETCH;
`else
                    state_d = mem_last ? DONE : MEM_FETCH;
`endif
                end
            end
            CSUM: begin
`ifdef DUMP_CHECKSUM_EN
                o_tx_valid = 1'b1;
                o_tx_data  = csum_q;
                if (i_tx_ready) begin
                    state_d = DONE;
                end
`else
                state_d = DONE;
`endif
            end
            DONE: begin
                o_busy  = 1'b0;
                o_done  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: shift word, byte/word counters and the held read addresses.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q      <= 32'h0;
            byte_cnt_q   <= 2'd0;
            fetch_wait_q <= 1'b0;
            reg_idx_q    <= '0;
            mem_idx_q    <= '0;
            o_reg_addr   <= 5'd0;
            o_mem_addr   <= '0;
`ifdef DUMP_CHECKSUM_EN
            csum_q       <= 8'h00;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        shift_q      <= i_pc[31:0];
                        byte_cnt_q   <= 2'd0;
                        fetch_wait_q <= 1'b0;
                        reg_idx_q    <= '0;
                        mem_idx_q    <= '0;
`ifdef DUMP_CHECKSUM_EN
                        csum_q       <= 8'h00;
`endif
                    end
                end
                PC, REG_SEND, MEM_SEND: begin
                    if (tx_fire) begin
                        shift_q    <= {shift_q[23:0], 8'h00};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef DUMP_CHECKSUM_EN
                        csum_q     <= csum_q ^ shift_q[31:24];
`endif
                        if (byte_last) begin
                            if (state_q == PC) begin
                                reg_idx_q  <= '0;
                                o_reg_addr <= 5'd0;
                            end else if (state_q == REG_SEND) begin
                                if (reg_last) begin
                                    mem_idx_q  <= '0;
                                    o_mem_addr <= '0;
                                end else begin
                                    reg_idx_q  <= reg_idx_next;
                                    o_reg_addr <= 5'(reg_idx_next);
                                end
                            end else if (!mem_last) begin
                                mem_idx_q  <= mem_idx_next;
                                o_mem_addr <= DATA_WIDTH'({mem_idx_next, 2'b00});
                            end
                        end
                    end
                end
                REG_FETCH: begin
                    fetch_wait_q <= ~fetch_wait_q;
                    if (fetch_wait_q) begin
                        shift_q <= i_reg_data[31:0];
                    end
                end
                MEM_FETCH: begin
                    fetch_wait_q <= ~fetch_wait_q;
                    if (fetch_wait_q) begin
                        shift_q <= i_mem_data[31:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/debug_dump_tx.md
DEBUG_DUMP_TX -- requirements
Module: debug_dump_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, datapath word width in bits.
REQ-002 SHALL have parameter REG_COUNT, default 32, register-file entries dumped.
REQ-003 SHALL have parameter MEM_WORDS, default 64, data-memory words dumped starting at byte address 0.
REQ-004 SHALL have port clk  input  1  single rising-edge clock for all logic.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port i_start  input  1  single-cycle request to begin a dump.
REQ-007 SHALL have port i_pc  input  DATA_WIDTH  PC value, sampled when the dump starts.
REQ-008 SHALL have port o_reg_addr  output  5  register-file read address.
REQ-009 SHALL have port i_reg_data  input  DATA_WIDTH  register read data, valid 1 cycle after o_reg_addr.
REQ-010 SHALL have port o_mem_addr  output  DATA_WIDTH  data-memory byte address, word aligned.
REQ-011 SHALL have port i_mem_data  input  DATA_WIDTH  memory read data, valid 1 cycle after o_mem_addr.
REQ-012 SHALL have port o_tx_data  output  8  outgoing byte.
REQ-013 SHALL have port o_tx_valid  output  1  o_tx_data holds a valid byte.
REQ-014 SHALL have port i_tx_ready  input  1  downstream (UART TX) accepts the byte.
REQ-015 SHALL have port o_busy  output  1  dump in progress.
REQ-016 SHALL have port o_done  output  1  one-cycle pulse after the final byte is accepted.

Function
REQ-017 SHALL send the frame: 0xA5 header; PC (4 bytes); regs 0..REG_COUNT-1 (4 bytes each); mem words 0..MEM_WORDS-1 (4 bytes each); every word MSB first.
REQ-018 SHALL implement FSM states IDLE, HEADER, PC, REG_FETCH, REG_SEND, MEM_FETCH, MEM_SEND, CSUM, DONE.
REQ-019 SHALL in IDLE with i_start=1 capture i_pc, assert o_busy, and enter HEADER; o_tx_valid=1 with 0xA5 in the following cycle.
REQ-020 SHALL count a byte as transferred only on a rising edge with o_tx_valid=1 and i_tx_ready=1.
REQ-021 SHALL hold o_tx_data and o_tx_valid stable while o_tx_valid=1 and i_tx_ready=0.
REQ-022 SHALL in REG_FETCH/MEM_FETCH drive the address for 1 cycle with o_tx_valid=0, latch read data into a 32-bit shift word, then send it in 4 bytes.
REQ-023 SHALL set o_mem_addr = 4*word index; o_reg_addr and o_mem_addr hold the last value outside fetch states.
REQ-024 SHALL advance from the last reg to mem word 0 and from the last mem word to CSUM (macro set) or DONE; index counters SHALL NOT wrap.
REQ-025 SHALL in DONE pulse o_done for exactly 1 cycle, clear o_busy, and return to IDLE.
REQ-026 SHALL ignore i_start while o_busy=1; a new i_start in the cycle after o_done SHALL start a fresh frame.
REQ-027 SHALL make each frame 1+4+4*REG_COUNT+4*MEM_WORDS bytes (389 at defaults; +1 with the checksum).

Reset
REQ-028 SHALL on reset enter IDLE and set o_tx_valid=0, o_tx_data=0, o_busy=0, o_done=0, o_reg_addr=0, o_mem_addr=0, and clear counters and the checksum.
REQ-029 SHALL on reset during a dump abort the frame immediately without completing the pending byte; no o_done.

Configuration
REQ-030 SHALL with DUMP_CHECKSUM_EN defined append a CSUM byte equal to the XOR of all bytes after the header, and clear the accumulator at start.
REQ-031 SHALL without DUMP_CHECKSUM_EN omit the CSUM state and byte; DONE follows the last mem byte.

Verification
REQ-032 SHALL cover: reset, i_pc=0x0000003C, regs r[n]=n, mem[k]=0x100+k, i_tx_ready=1, start -> 389 bytes: A5,00,00,00,3C,00,00,00,00,00,00,00,01..., o_done 1 cycle.
REQ-033 SHALL cover: same as REQ-032 with i_tx_ready toggling randomly -> identical byte stream, no byte dropped or duplicated, data stable during stalls.
REQ-034 SHALL cover: i_start pulsed again at byte 50 -> ignored, frame length unchanged.
REQ-035 SHALL cover: reset asserted at byte 200 -> o_tx_valid=0 and o_busy=0 next cycle, no o_done; a new start yields a full frame beginning with A5.
REQ-036 SHALL cover: DUMP_CHECKSUM_EN set, all regs and mem 0, i_pc=0x12345678 -> 390 bytes, last byte 0x08.
REQ-037 SHALL cover: i_start in the cycle after o_done -> second complete frame, back-to-back.
